trdb_filter_ranges: RTL and testbench

Parametrised instruction-trace qualification filter for the trdb trace encoder. It sits between the retired-instruction interface and the packet emitter. Each cycle it decides whether the retired instruction is traced, using N_RANGES programmable address comparators, a privilege filter and the global enable. Each comparator works either as an inclusive-window range or as a start/stop trigger pair. It also requests encoder deactivation on configured stop hits.

---
 rtl/trdb_filter_ranges.sv | 94 +++++++++
 tb/tb_trdb_filter_ranges.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_filter_ranges.sv
// rtl/trdb_filter_ranges.sv - instruction-trace qualification filter with window/trigger address comparators
module trdb_filter_ranges #(
    parameter int XLEN     = 32,
    parameter int N_RANGES = 4,
    parameter int PRIV_W   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       trace_activated_i,
    input  logic                       apply_filters_i,
    input  logic                       iaddr_valid_i,
    input  logic [XLEN-1:0]            iaddr_i,
    input  logic [PRIV_W-1:0]          priv_lvl_i,
    input  logic                       trace_selected_priv_i,
    input  logic [PRIV_W-1:0]          which_priv_i,
    input  logic [N_RANGES-1:0]        range_en_i,
    input  logic [N_RANGES-1:0]        range_mode_i,
    input  logic [N_RANGES-1:0]        range_stop_deact_i,
    input  logic [N_RANGES*XLEN-1:0]   range_lower_i,
    input  logic [N_RANGES*XLEN-1:0]   range_higher_i,
    output logic                       trace_range_match_o,
    output logic                       trace_priv_match_o,
    output logic                       trace_qualified_o,
    output logic                       trace_req_deactivate_o,
    output logic [N_RANGES-1:0]        trigger_active_o
);

    logic [N_RANGES-1:0] active_q;
    logic [N_RANGES-1:0] active_d;
    logic [N_RANGES-1:0] start_hit;
    logic [N_RANGES-1:0] stop_hit;
    logic [N_RANGES-1:0] chan_hit;
    logic [N_RANGES-1:0] deact_hit;

    logic range_match;
    logic priv_match;
    logic qualified;
    logic req_deact;

    for (genvar k = 0; k < N_RANGES; k++) begin : g_chan
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] hi;
        logic            win_hit;
        logic            clear;

        assign lo      = range_lower_i[k*XLEN +: XLEN];
        assign hi      = range_higher_i[k*XLEN +: XLEN];
        // Swapped bounds fall out naturally: no address satisfies both compares.
        assign win_hit = (lo <= iaddr_i) && (iaddr_i <= hi);

        assign start_hit[k] = iaddr_valid_i && (iaddr_i == lo);
        assign stop_hit[k]  = iaddr_valid_i && (iaddr_i == hi);

        assign chan_hit[k]  = range_en_i[k] &&
                              (range_mode_i[k] ? (active_q[k] || start_hit[k]) : win_hit);

        assign deact_hit[k] = range_en_i[k] && range_mode_i[k] &&
                              range_stop_deact_i[k] && stop_hit[k];

        // Clear beats stop, stop beats start, so start==stop traces a single instruction.
        assign clear       = !range_en_i[k] || !range_mode_i[k] || !trace_activated_i;
        assign active_d[k] = clear        ? 1'b0 :
                             stop_hit[k]  ? 1'b0 :
                             start_hit[k] ? 1'b1 : active_q[k];
    end

    assign range_match = (range_en_i == '0) || (|chan_hit);
    assign priv_match  = !trace_selected_priv_i || (priv_lvl_i == which_priv_i);
    assign qualified   = iaddr_valid_i && trace_activated_i &&
                         (!apply_filters_i || (range_match && priv_match));
    assign req_deact   = iaddr_valid_i && trace_activated_i && (|deact_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q               <= '0;
            trace_range_match_o    <= 1'b0;
            trace_priv_match_o     <= 1'b0;
            trace_qualified_o      <= 1'b0;
            trace_req_deactivate_o <= 1'b0;
        end else begin
            active_q               <= active_d;
            trace_qualified_o      <= qualified;
            trace_req_deactivate_o <= req_deact;
            // Match flags describe the last retired instruction, so they hold across gaps.
            if (iaddr_valid_i) begin
                trace_range_match_o <= range_match;
                trace_priv_match_o  <= priv_match;
            end
        end
    end

    assign trigger_active_o = active_q;

endmodule

// File: tb/tb_trdb_filter_ranges.sv
// tb/tb_trdb_filter_ranges.sv - directed and randomized checks of trdb_filter_ranges against a reference model
module tb_trdb_filter_ranges;

    localparam int XLEN = 32;
    localparam int N    = 4;
    localparam int PW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            act;
    logic            apply;
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [PW-1:0]   priv;
    logic            sel_priv;
    logic [PW-1:0]   which;
    logic [N-1:0]    en;
    logic [N-1:0]    mode;
    logic [N-1:0]    sd;
    logic [XLEN-1:0] lo_a [N];
    logic [XLEN-1:0] hi_a [N];
    logic [N*XLEN-1:0] lo_flat;
    logic [N*XLEN-1:0] hi_flat;

    logic          range_match;
    logic          priv_match;
    logic          qualified;
    logic          req_deact;
    logic [N-1:0]  trig_active;

    always_comb begin
        lo_flat = '0;
        hi_flat = '0;
        for (int k = 0; k < N; k++) begin
            lo_flat[k*XLEN +: XLEN] = lo_a[k];
            hi_flat[k*XLEN +: XLEN] = hi_a[k];
        end
    end

    trdb_filter_ranges #(.XLEN(XLEN), .N_RANGES(N), .PRIV_W(PW)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .trace_activated_i      (act),
        .apply_filters_i        (apply),
        .iaddr_valid_i          (valid),
        .iaddr_i                (addr),
        .priv_lvl_i             (priv),
        .trace_selected_priv_i  (sel_priv),
        .which_priv_i           (which),
        .range_en_i             (en),
        .range_mode_i           (mode),
        .range_stop_deact_i     (sd),
        .range_lower_i          (lo_flat),
        .range_higher_i         (hi_flat),
        .trace_range_match_o    (range_match),
        .trace_priv_match_o     (priv_match),
        .trace_qualified_o      (qualified),
        .trace_req_deactivate_o (req_deact),
        .trigger_active_o       (trig_active)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference state: what the outputs should read after the next edge.
    bit m_range, m_priv, m_qual, m_deact;
    bit m_active [N];

    task automatic model_edge();
        bit any_en, rm, pm, dq;
        bit nxt [N];
        any_en = 0; rm = 0; dq = 0;
        for (int k = 0; k < N; k++) begin
            bit h;
            h = 0;
            if (en[k]) begin
                any_en = 1;
                if (!mode[k]) h = (addr >= lo_a[k]) && (addr <= hi_a[k]);
                else          h = m_active[k] || (valid && addr == lo_a[k]);
                if (mode[k] && sd[k] && valid && addr == hi_a[k]) dq = 1;
            end
            if (h) rm = 1;
            if (!en[k] || !mode[k] || !act)  nxt[k] = 0;
            else if (valid && addr == hi_a[k]) nxt[k] = 0;
            else if (valid && addr == lo_a[k]) nxt[k] = 1;
            else                               nxt[k] = m_active[k];
        end
        if (!any_en) rm = 1;
        pm = !sel_priv || (priv == which);
        if (rst) begin
            m_range = 0; m_priv = 0; m_qual = 0; m_deact = 0;
            for (int k = 0; k < N; k++) m_active[k] = 0;
        end else begin
            if (valid) begin
                m_range = rm;
                m_priv  = pm;
            end
            m_qual  = valid && act && (!apply || (rm && pm));
            m_deact = valid && act && dq;
            for (int k = 0; k < N; k++) m_active[k] = nxt[k];
        end
    endtask

    task automatic step(input logic v, input logic [XLEN-1:0] a, input logic r);
        logic [N-1:0] exp_act;
        valid = v;
        addr  = a;
        rst   = r;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) exp_act[k] = m_active[k];
        check("range_match", range_match, m_range);
        check("priv_match",  priv_match,  m_priv);
        check("qualified",   qualified,   m_qual);
        check("req_deact",   req_deact,   m_deact);
        check("trig_active", trig_active, exp_act);
    endtask

    task automatic send(input logic [XLEN-1:0] a);
        step(1'b1, a, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0);
    endtask

    task automatic clear_cfg();
        act = 1; apply = 1; sel_priv = 0; which = 0; priv = 0;
        en = '0; mode = '0; sd = '0;
        for (int k = 0; k < N; k++) begin
            lo_a[k] = '0;
            hi_a[k] = '0;
        end
    endtask

    logic [XLEN-1:0] win_addrs [4];
    logic [3:0]      win_exp;

    initial begin
        clear_cfg();
        valid = 0; addr = '0; rst = 1;
        for (int k = 0; k < N; k++) m_active[k] = 0;

        // Reset state
        step(1'b0, '0, 1'b1);
        check("rst_qual",  qualified,   0);
        check("rst_range", range_match, 0);
        check("rst_act",   trig_active, 0);

        // Inclusive window on channel 0
        en[0] = 1; lo_a[0] = 32'h1000; hi_a[0] = 32'h1FFF;
        win_addrs[0] = 32'h0FFC; win_addrs[1] = 32'h1000;
        win_addrs[2] = 32'h1FFF; win_addrs[3] = 32'h2000;
        win_exp = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            send(win_addrs[i]);
            check("win_qual", qualified, win_exp[i]);
        end
        // Swapped bounds never hit
        lo_a[0] = 32'h2000; hi_a[0] = 32'h1000;
        send(32'h1000); check("swap_qual", qualified, 0);
        send(32'h1800); check("swap_qual", qualified, 0);
        send(32'h2000); check("swap_qual", qualified, 0);

        // Trigger pair on channel 1 with stop-deactivate
        clear_cfg();
        en[1] = 1; mode[1] = 1; sd[1] = 1; lo_a[1] = 32'h400; hi_a[1] = 32'h480;
        send(32'h3FC); check("trg_qual", qualified, 0); check("trg_act", trig_active[1], 0);
        send(32'h400); check("trg_qual", qualified, 1); check("trg_act", trig_active[1], 1);
        send(32'h440); check("trg_qual", qualified, 1); check("trg_act", trig_active[1], 1);
        idle();        check("gap_qual", qualified, 0); check("gap_range", range_match, 1);
        send(32'h480); check("trg_qual", qualified, 1); check("trg_act", trig_active[1], 0);
                       check("trg_deact", req_deact, 1);
        send(32'h484); check("trg_qual", qualified, 0); check("trg_deact", req_deact, 0);

        // No deactivate request while trace is off
        act = 0;
        send(32'h480); check("off_deact", req_deact, 0);
        act = 1;

        // start == stop traces exactly one instruction
        lo_a[1] = 32'h500; hi_a[1] = 32'h500;
        send(32'h500); check("same_qual", qualified, 1); check("same_act", trig_active[1], 0);
        send(32'h504); check("same_qual", qualified, 0);

        // Privilege filter alone
        clear_cfg();
        sel_priv = 1; which = 3;
        priv = 0; send(32'h10); check("priv_m", priv_match, 0); check("priv_q", qualified, 0);
        priv = 3; send(32'h14); check("priv_m", priv_match, 1); check("priv_q", qualified, 1);
        priv = 1; send(32'h18); check("priv_m", priv_match, 0); check("priv_q", qualified, 0);
        apply = 0;
        priv = 0; send(32'h10); check("nof_q", qualified, 1);
        priv = 3; send(32'h14); check("nof_q", qualified, 1);
        priv = 1; send(32'h18); check("nof_q", qualified, 1);

        // Dropping trace_activated clears an open trigger window
        clear_cfg();
        en[1] = 1; mode[1] = 1; lo_a[1] = 32'h400; hi_a[1] = 32'h480;
        send(32'h400); check("drop_act", trig_active[1], 1);
        act = 0; idle(); check("drop_act", trig_active[1], 0);
        act = 1; send(32'h440); check("drop_qual", qualified, 0);

        // Reset inside an open trigger window
        send(32'h400); check("rmid_act", trig_active[1], 1);
        step(1'b1, 32'h440, 1'b1);
        check("rmid_qual", qualified, 0); check("rmid_act", trig_active, 0);
        check("rmid_deact", req_deact, 0);
        send(32'h440); check("rmid_post", qualified, 0);

        // Randomized traffic over a small address pool so comparators actually hit
        for (int i = 0; i < 3000; i++) begin
            if (i % 8 == 0) begin
                en       = N'($urandom);
                mode     = N'($urandom);
                sd       = N'($urandom);
                apply    = ($urandom_range(0, 3) != 0);
                sel_priv = $urandom_range(0, 1) == 1;
                which    = PW'($urandom);
                for (int k = 0; k < N; k++) begin
                    lo_a[k] = 32'h100 + 4 * $urandom_range(0, 15);
                    hi_a[k] = 32'h100 + 4 * $urandom_range(0, 15);
                end
            end
            act  = ($urandom_range(0, 19) != 0);
            priv = PW'($urandom);
            step($urandom_range(0, 3) != 0, 32'h100 + 4 * $urandom_range(0, 15),
                 $urandom_range(0, 99) < 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
